// File: rtl/inv_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes_seq
//   Sequential AES InvSubBytes unit for the iterative decryption round.
//   A 128-bit state is captured over a valid/ready handshake. LANES bytes per
//   cycle are then replaced by their inverse S-box value, and the finished
//   state is offered on a valid/ready output port. Each pass through the
//   work register takes N = 16/LANES cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears FSM, counter and state)
//   in_valid   in_state is valid
//   in_ready   block can accept a state (IDLE only)
//   in_state   input state, byte k = in_state[127-8k -: 8], byte 0 = MSB
//   out_valid  out_state holds a finished result (DONE only)
//   out_ready  downstream accepts out_state
//   out_state  InvSubBytes(in_state), same byte order
//   busy       high while in RUN or DONE
// ---------------------------------------------------------------------------
module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int N     = 16 / LANES;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [127:0]     wreg;
    logic [127:0]     run_next;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = prod x^(2^i), i = 1..7.
    // An input of zero naturally yields zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Substitute the LANES bytes selected by cnt; every other byte passes through.
    always_comb begin
        run_next = wreg;
        for (int l = 0; l < LANES; l++) begin
            run_next[127 - 8 * (int'(cnt) * LANES + l) -: 8] =
                inv_sbox(wreg[127 - 8 * (int'(cnt) * LANES + l) -: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            wreg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        wreg  <= in_state;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    wreg <= run_next;
                    if (cnt == CNT_W'(N - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_state = wreg;

endmodule
